// File: rtl/fpu_sequencer_pkg.sv
// Shared definitions for the FPU command sequencer:
// FSM encoding, operation codes and the queued command record.
package fpu_sequencer_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CMD_W = 70;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
  } cmd_t;

endpackage

// File: rtl/fpu_sequencer_cmd_fifo.sv
// Command queue: power-of-two FIFO with wrapping pointers.
// Full is taken from the registered count, so a same-cycle pop never frees a slot early.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 70
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [4:0]   count,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == 5'(DEPTH));
  assign empty = (cnt_q == 5'd0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // Next pointer and occupancy values.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + 5'(do_push) - 5'(do_pop);
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Queues FPU commands and runs them one at a time through a
// start/done handshake, with a per-operation timeout.
module fpu_sequencer
  import fpu_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_r,
  input  logic        fpu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_r,
  output logic        rsp_err,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic [4:0]  q_count
);

  cmd_t        in_cmd, head;
  logic        pop, full, empty;
  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] rsp_r_q, rsp_r_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  rsp_tag_q, rsp_tag_d;
  logic [7:0]  tmo_q, tmo_d, tmo_inc;
  logic        tmo_hit;

  assign in_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};

  fpu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;
  assign fpu_a     = a_q;
  assign fpu_b     = b_q;
  assign fpu_op    = op_q;
  assign fpu_start = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_r     = rsp_r_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tag   = rsp_tag_q;
  assign busy      = (state_q != S_IDLE) || !empty;

  // Sequencer FSM; in WAIT_LOW the timeout wins since no result is valid there.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tag_d     = tag_q;
    rsp_r_d   = rsp_r_q;
    rsp_err_d = rsp_err_q;
    rsp_tag_d = rsp_tag_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    tmo_inc   = tmo_q + 8'd1;
    tmo_hit   = (tmo_inc == 8'(TIMEOUT));
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = head.a;
          b_d     = head.b;
          op_d    = head.op;
          tag_d   = head.tag;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = 8'd0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        tmo_d = tmo_inc;
        if (tmo_hit) begin
          rsp_r_d   = 32'd0;
          rsp_err_d = 1'b1;
          rsp_tag_d = tag_q;
          state_d   = S_RESP;
        end else if (!fpu_done) begin
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        tmo_d = tmo_inc;
        if (fpu_done) begin
          rsp_r_d   = fpu_r;
          rsp_err_d = 1'b0;
          rsp_tag_d = tag_q;
          state_d   = S_RESP;
        end else if (tmo_hit) begin
          rsp_r_d   = 32'd0;
          rsp_err_d = 1'b1;
          rsp_tag_d = tag_q;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      rsp_r_q   <= '0;
      rsp_err_q <= 1'b0;
      rsp_tag_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      rsp_r_q   <= rsp_r_d;
      rsp_err_q <= rsp_err_d;
      rsp_tag_q <= rsp_tag_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule
